// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared constants for the control/PC pipeline chain.
//
// Contents:
//   STG_EX/STG_MEM/STG_WB : stage indices of the default three-stage chain.
//   CTRL_W_DEF            : default control word width.
//   *_LO/*_HI/*_BIT       : field positions inside the control word.
//   CTRL_NOP              : control word of a bubble; all-zero means no
//                           register-file or memory write can happen.
package pipe_pkg;

  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  localparam int unsigned CTRL_W_DEF = 15;

  // Control word layout (LSB first).
  localparam int unsigned ALU_OP_LO = 0;
  localparam int unsigned ALU_OP_HI = 3;
  localparam int unsigned MEM_EN_LO = 4;   // [4] read, [5] write
  localparam int unsigned MEM_EN_HI = 5;
  localparam int unsigned RF_EN_BIT = 6;

  localparam int unsigned CTRL_NOP = 0;

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- one {valid, ctrl, pc} register of the pipeline chain.
//
// Ports:
//   clk, reset      : clock, asynchronous active-low reset (clears to bubble)
//   load            : capture d_* at the edge (otherwise a bubble is loaded)
//   kill            : force a bubble at the edge; beats hold and load
//   hold            : keep current contents; beats load
//   d_valid/d_ctrl/d_pc : next contents
//   q_valid/q_ctrl/q_pc : registered contents
module pipe_stage_reg #(
  parameter int CTRL_W = 15,
  parameter int PC_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              kill,
  input  logic              hold,
  input  logic              d_valid,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic [PC_W-1:0]   d_pc,
  output logic              q_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic [PC_W-1:0]   q_pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_pc    <= '0;
    end else if (kill) begin
      q_valid <= 1'b0;
      q_ctrl  <= '0;
      q_pc    <= '0;
    end else if (!hold) begin
      if (load) begin
        q_valid <= d_valid;
        q_ctrl  <= d_ctrl;
        q_pc    <= d_pc;
      end else begin
        // Not loading while advancing means a bubble is injected.
        q_valid <= 1'b0;
        q_ctrl  <= '0;
        q_pc    <= '0;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl_chain.sv
// pipe_ctrl_chain -- control word / PC pipeline from ID through STAGES
// downstream stage registers (0 = EX, 1 = MEM, 2 = WB by default).
//
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   in_valid/in_ctrl/in_pc : instruction presented by ID
//   stall             : load-use stall; hold ID, bubble into stage 0
//   freeze            : global hold; nothing advances (flush still kills)
//   flush[k]          : kill stage k at the edge
//   in_ready          : ID instruction accepted this cycle
//   stage_valid/stage_ctrl/stage_pc : per-stage contents, stage k at
//                       [k*W +: W] of the flattened buses
// Optional (macro PIPE_PERF_EN):
//   retire_cnt        : instructions leaving the last stage
//   bubble_cnt        : stall cycles that injected a bubble
// STAGES is meant to lie in 2..8.
module pipe_ctrl_chain
  import pipe_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int PC_W   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [CTRL_W-1:0]        in_ctrl,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     stall,
  input  logic                     freeze,
  input  logic [STAGES-1:0]        flush,
  output logic                     in_ready,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*CTRL_W-1:0] stage_ctrl,
  output logic [STAGES*PC_W-1:0]   stage_pc
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]              retire_cnt,
  output logic [31:0]              bubble_cnt
`endif
);

  logic [STAGES-1:0] vld_p;
  logic [CTRL_W-1:0] ctrl_p [STAGES];
  logic [PC_W-1:0]   pc_p   [STAGES];

  assign in_ready = ~stall & ~freeze;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic              d_vld;
    logic [CTRL_W-1:0] d_ctrl;
    logic [PC_W-1:0]   d_pc;
    logic              ld;

    if (k == STG_EX) begin : g_first
      // An invalid ID slot enters as a clean bubble, never with stale ctrl.
      assign d_vld  = in_valid;
      assign d_ctrl = in_valid ? in_ctrl : CTRL_W'(CTRL_NOP);
      assign d_pc   = in_valid ? in_pc : '0;
      assign ld     = ~stall;
    end else begin : g_rest
      assign d_vld  = vld_p[k-1];
      assign d_ctrl = ctrl_p[k-1];
      assign d_pc   = pc_p[k-1];
      assign ld     = 1'b1;
    end

    // ---- stage k register boundary ----
    pipe_stage_reg #(
      .CTRL_W (CTRL_W),
      .PC_W   (PC_W)
    ) u_reg (
      .clk     (clk),
      .reset   (reset),
      .load    (ld),
      .kill    (flush[k]),
      .hold    (freeze),
      .d_valid (d_vld),
      .d_ctrl  (d_ctrl),
      .d_pc    (d_pc),
      .q_valid (vld_p[k]),
      .q_ctrl  (ctrl_p[k]),
      .q_pc    (pc_p[k])
    );

    assign stage_valid[k]              = vld_p[k];
    assign stage_ctrl[k*CTRL_W +: CTRL_W] = ctrl_p[k];
    assign stage_pc[k*PC_W +: PC_W]    = pc_p[k];
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (!freeze && !flush[STAGES-1] && vld_p[STAGES-1])
        retire_cnt <= retire_cnt + 32'd1;
      if (stall && !freeze)
        bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule
